iob_native_ram_slave: RTL and testbench
=======================================

Name: iob_native_ram_slave

Overview:
- Responder (target) end of the native valid/address/wdata/wstrb → rdata/ready memory bus driven by the CPU wrapper's instruction and data ports.
- Word-addressed SRAM with per-byte write strobes and a programmable wait-state counter, so system software and firmware tests see realistic memory latency.
- Sits on an interconnect leaf, one instance per memory region.

Parameters:
- ADDR_W, 32: bus address width.
- DATA_W, 32: bus data width; must be 32.
- MEM_ADDR_W, 12: log2 of memory depth in words; range 2..20.
- WAIT_CYCLES, 2: extra wait states before the access; range 0..15.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset; one clock, asynchronous, active-low (`resetn`).
- valid  input  1  request valid; the initiator masks it low during the ready cycle.
- address  input  ADDR_W  byte address; bits [1:0] are ignored.
- wdata  input  DATA_W  write data.
- wstrb  input  DATA_W/8  byte write enables; all-zero means a read.
- rdata  output  DATA_W  read data; valid only while ready=1.
- ready  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async assert, sync deassert):
  - FSM goes to IDLE; ready=0, rdata=0, counter=0, latched request cleared.
  - Memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if valid=1, latch address/wdata/wstrb, load counter=WAIT_CYCLES, go to WAIT.
  - WAIT: if counter≠0, decrement. If counter=0, perform the access at this edge and go to RESP.
  - RESP: ready=1 for exactly one cycle, then go to IDLE.
- Access:
  - Word index = latched address[MEM_ADDR_W+1:2]; upper bits are ignored, so the memory aliases/wraps.
  - Write: each byte i with wstrb[i]=1 is updated. rdata=0 in RESP.
  - Read: rdata = memory word, registered at the access edge, held during RESP, returned to 0 in IDLE.
- Latency: first valid sampled in cycle N → ready=1 in cycle N+WAIT_CYCLES+2. Throughput is one transaction per WAIT_CYCLES+3 cycles.
- Back-to-back: valid in the RESP cycle is ignored. valid in the cycle after RESP is accepted as a new request.
- valid dropped during WAIT (protocol violation): the transaction still completes and ready is still pulsed.
- valid held high after ready: treated as a new request (an initiator without masking issues a duplicate).
- Reset mid-transaction: the transaction is abandoned and no ready is issued. A write is committed only if reset deasserts after the access edge.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro IOB_NATIVE_RAM_SLAVE_ERR_EN.
- Defined:
  - Extra output port err (1 bit), reset 0, pulsed together with ready.
  - err=1 when any latched address bit above MEM_ADDR_W+1 is nonzero.
  - On error: the write is suppressed and read rdata=32'hDEAD_BEEF.
- Undefined:
  - Port err is absent.
  - Out-of-range addresses alias as described above.

Decomposition:
- Package iob_native_ram_pkg:
  - FSM state encoding (2-bit).
  - Error read pattern 32'hDEAD_BEEF.
  - Request/response field widths consistent with the interconnect REQ_W/RESP_W.
- Sub-module iob_native_ram_sp_be:
  - Single-port, byte-enable, synchronous-read array.
  - Parameters MEM_ADDR_W and DATA_W.
  - Ports en, we[3:0], addr, din, dout.
  - The FSM/counter stays in the top module.

Test Plan:
- Reset check: hold resetn=0 with random inputs → ready=0, rdata=0. Release → first valid in cycle N gives ready in cycle N+4 (WAIT_CYCLES=2).
- Full write then read: write 32'h1234_5678 to addr 0x10 with wstrb=4'hF. Then read 0x10 → rdata=32'h1234_5678 with ready; rdata=0 on the following cycle.
- Byte strobes: write 32'hAABB_CCDD to 0x20 with wstrb=4'b0101 over prior 32'h0 → read returns 32'h00BB_00DD.
- Aliasing and latency (MEM_ADDR_W=4, WAIT_CYCLES=0): write 32'hCAFE_F00D to 0x40 → read 0x00 returns 32'hCAFE_F00D, ready 2 cycles after valid.
  - With ERR_EN defined: err=1, the write is suppressed, and the read of 0x40 returns 32'hDEAD_BEEF.
- Masked back-to-back reads: the initiator masks valid during ready, reads 0x10, 0x14, 0x18 → ready pulses 5 cycles apart and exactly 3 ready pulses are seen.
- Reset mid-write: resetn=0 during WAIT of a write 32'h5555_5555 to 0x30 → no ready pulse, and a later read of 0x30 returns the old value.

Source files
------------

// File: rtl/iob_native_ram_pkg.sv
// Shared types and constants for the native-bus RAM responder.
package iob_native_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
  localparam int          CNT_W     = 4;

  // Interconnect request {valid, address, wdata, wstrb} and response {ready, rdata} widths.
  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/iob_native_ram_sp_be.sv
// Single-port byte-enable RAM with synchronous read; contents are never reset.
module iob_native_ram_sp_be #(
  parameter int MEM_ADDR_W = 12,
  parameter int DATA_W     = 32
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [DATA_W/8-1:0]     we,
  input  logic [MEM_ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout
);

  logic [DATA_W-1:0] mem [2**MEM_ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < DATA_W / 8; i++) begin
        if (we[i]) mem[addr][i*8 +: 8] <= din[i*8 +: 8];
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/iob_native_ram_slave.sv
// Native-bus RAM responder with programmable wait states.
// Optional error reporting for out-of-range addresses: IOB_NATIVE_RAM_SLAVE_ERR_EN.
module iob_native_ram_slave
  import iob_native_ram_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_ADDR_W  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready
`ifdef IOB_NATIVE_RAM_SLAVE_ERR_EN
  ,
  output logic                err
`endif
);

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [MEM_ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic                  ready_q;
  logic                  rd_q;

  logic                  mem_en;
  logic [DATA_W/8-1:0]   mem_we;
  logic [DATA_W-1:0]     mem_dout;

  // Byte-lane bits and bits above the memory index take no part in the access.
  logic unused_addr;
  assign unused_addr = ^{address[1:0], address[ADDR_W-1:MEM_ADDR_W+2]};

  assign mem_en = (state_q == ST_WAIT) && (cnt_q == '0);

`ifdef IOB_NATIVE_RAM_SLAVE_ERR_EN
  logic oor_d;
  logic oor_q;
  logic err_q;

  assign oor_d  = |address[ADDR_W-1:MEM_ADDR_W+2];
  assign mem_we = (mem_en && !oor_q) ? wstrb_q : '0;
  assign rdata  = rd_q ? (err_q ? DATA_W'(ERR_RDATA) : mem_dout) : '0;
  assign err    = err_q;
`else
  assign mem_we = mem_en ? wstrb_q : '0;
  assign rdata  = rd_q ? mem_dout : '0;
`endif

  assign ready = ready_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready_q <= 1'b0;
      rd_q    <= 1'b0;
`ifdef IOB_NATIVE_RAM_SLAVE_ERR_EN
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
      rd_q    <= 1'b0;
`ifdef IOB_NATIVE_RAM_SLAVE_ERR_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (valid) begin
            idx_q   <= address[MEM_ADDR_W+1:2];
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            cnt_q   <= CNT_W'(WAIT_CYCLES);
            state_q <= ST_WAIT;
`ifdef IOB_NATIVE_RAM_SLAVE_ERR_EN
            oor_q   <= oor_d;
`endif
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            // The RAM access fires on this same edge, so data lands for RESP.
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            rd_q    <= (wstrb_q == '0);
`ifdef IOB_NATIVE_RAM_SLAVE_ERR_EN
            err_q   <= oor_q;
`endif
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  iob_native_ram_sp_be #(
    .MEM_ADDR_W (MEM_ADDR_W),
    .DATA_W     (DATA_W)
  ) u_mem (
    .clk  (clk),
    .en   (mem_en),
    .we   (mem_we),
    .addr (idx_q),
    .din  (wdata_q),
    .dout (mem_dout)
  );

endmodule

// File: tb/tb_iob_native_ram_slave.sv
// Randomized bench for iob_native_ram_slave: two configurations share one stimulus
// stream and are compared every cycle against a transaction-level model.
module tb_iob_native_ram_slave;

`ifdef IOB_NATIVE_RAM_SLAVE_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        valid;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b;
  logic        err_a, err_b;

  iob_native_ram_slave #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MEM_ADDR_W  (12),
    .WAIT_CYCLES (2)
  ) u_dut_a (
    .clk     (clk),
    .resetn  (resetn),
    .valid   (valid),
    .address (address),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .rdata   (rdata_a),
    .ready   (ready_a)
`ifdef IOB_NATIVE_RAM_SLAVE_ERR_EN
    ,
    .err     (err_a)
`endif
  );

  iob_native_ram_slave #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MEM_ADDR_W  (4),
    .WAIT_CYCLES (0)
  ) u_dut_b (
    .clk     (clk),
    .resetn  (resetn),
    .valid   (valid),
    .address (address),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .rdata   (rdata_b),
    .ready   (ready_b)
`ifdef IOB_NATIVE_RAM_SLAVE_ERR_EN
    ,
    .err     (err_b)
`endif
  );

`ifndef IOB_NATIVE_RAM_SLAVE_ERR_EN
  assign err_a = 1'b0;
  assign err_b = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Transaction-level model, one slot per instance (0 = A, 1 = B).
  int          cyc;
  int          free_c [2];
  int          acc_c  [2];
  int          resp_c [2];
  bit          acc_p  [2];
  logic [31:0] pa     [2];
  logic [31:0] pd     [2];
  logic [3:0]  ps     [2];
  logic [31:0] resp_d [2];
  logic [3:0]  resp_k [2];
  bit          resp_e [2];
  logic [31:0] md     [2][4096];
  logic [3:0]  mk     [2][4096];

  bit          rdy_s  [2];
  logic [31:0] dat_s  [2];
  bit          mask_en;

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int maw(input int k);
    return (k == 0) ? 12 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int idx;
    bit e;
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        acc_p[k]  = 1'b0;
        resp_c[k] = -1;
        free_c[k] = 0;
      end else begin
        if (acc_p[k] && cyc == acc_c[k]) begin
          idx = int'((pa[k] >> 2) & ((32'd1 << maw(k)) - 32'd1));
          e   = ERR_ON && ((pa[k] >> (maw(k) + 2)) != 32'd0);
          if (ps[k] == 4'h0) begin
            resp_d[k] = e ? 32'hDEAD_BEEF : md[k][idx];
            resp_k[k] = e ? 4'hF : mk[k][idx];
          end else begin
            if (!e) begin
              for (int b = 0; b < 4; b++) begin
                if (ps[k][b]) begin
                  md[k][idx][8*b +: 8] = pd[k][8*b +: 8];
                  mk[k][idx][b] = 1'b1;
                end
              end
            end
            resp_d[k] = 32'h0;
            resp_k[k] = 4'hF;
          end
          resp_e[k] = e;
          resp_c[k] = cyc + 1;
          acc_p[k]  = 1'b0;
        end
        if (valid && cyc >= free_c[k]) begin
          pa[k]     = address;
          pd[k]     = wdata;
          ps[k]     = wstrb;
          acc_c[k]  = cyc + wc(k) + 1;
          free_c[k] = cyc + wc(k) + 3;
          acc_p[k]  = 1'b1;
        end
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    logic        r, er, exp_r;
    logic [31:0] d, m;
    string       n;
    for (int k = 0; k < 2; k++) begin
      r  = (k == 0) ? ready_a : ready_b;
      d  = (k == 0) ? rdata_a : rdata_b;
      er = (k == 0) ? err_a : err_b;
      n  = (k == 0) ? "A" : "B";
      exp_r = resetn && (cyc == resp_c[k]);
      chk({n, ".ready"}, 32'(r), 32'(exp_r));
      if (exp_r) begin
        m = {{8{resp_k[k][3]}}, {8{resp_k[k][2]}}, {8{resp_k[k][1]}}, {8{resp_k[k][0]}}};
        chk({n, ".rdata"}, d & m, resp_d[k] & m);
      end else begin
        chk({n, ".rdata_idle"}, d, 32'h0);
      end
      if (ERR_ON) chk({n, ".err"}, 32'(er), 32'(exp_r && resp_e[k]));
      rdy_s[k] = r;
      dat_s[k] = d;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    if (mask_en && ready_a) valid = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // One request pulse; returns data and latency seen on each instance.
  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] ra, output logic [31:0] rb,
                     output int la, output int lb, output logic [31:0] ra_next);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    la = -1; lb = -1; ra = '0; rb = '0; ra_next = '1;
    for (int j = 0; j < 8; j++) begin
      cycle();
      if (j == 0) valid = 1'b0;
      if (la >= 0 && j == la + 1) ra_next = dat_s[0];
      if (rdy_s[0] && la < 0) begin la = j; ra = dat_s[0]; end
      if (rdy_s[1] && lb < 0) begin lb = j; rb = dat_s[1]; end
    end
  endtask

  initial begin
    logic [31:0] ra, rb, rn;
    int          la, lb, n, extra, rst_hold;
    int          tm [3];

    checks = 0; failures = 0; cyc = 0; mask_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      free_c[k] = 0; resp_c[k] = -1; acc_p[k] = 1'b0;
      for (int i = 0; i < 4096; i++) mk[k][i] = 4'h0;
    end

    // Reset with random bus activity
    resetn = 1'b0; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
    for (int i = 0; i < 5; i++) begin
      valid = 1'($urandom); address = $urandom; wdata = $urandom; wstrb = 4'($urandom);
      cycle();
      chk("reset_ready", 32'(rdy_s[0]), 32'h0);
      chk("reset_rdata", dat_s[0], 32'h0);
    end
    valid = 1'b0;
    resetn = 1'b1;
    cycle();

    // Full write then read
    txn(32'h10, 32'h1234_5678, 4'hF, ra, rb, la, lb, rn);
    chk("lat_a", 32'(la), 32'd4);
    chk("lat_b", 32'(lb), 32'd2);
    txn(32'h10, 32'hFFFF_FFFF, 4'h0, ra, rb, la, lb, rn);
    chk("read_a", ra, 32'h1234_5678);
    chk("read_a_after", rn, 32'h0);
    chk("read_b", rb, 32'h1234_5678);

    // Byte strobes
    txn(32'h20, 32'h0, 4'hF, ra, rb, la, lb, rn);
    txn(32'h20, 32'hAABB_CCDD, 4'b0101, ra, rb, la, lb, rn);
    txn(32'h20, 32'h0, 4'h0, ra, rb, la, lb, rn);
    chk("strobe_a", ra, 32'h00BB_00DD);
    chk("strobe_b", rb, 32'h00BB_00DD);

    // Aliasing on the 16-word instance
    txn(32'h40, 32'hCAFE_F00D, 4'hF, ra, rb, la, lb, rn);
    if (ERR_ON) begin
      txn(32'h40, 32'h0, 4'h0, ra, rb, la, lb, rn);
      chk("err_read_b", rb, 32'hDEAD_BEEF);
    end else begin
      txn(32'h00, 32'h0, 4'h0, ra, rb, la, lb, rn);
      chk("alias_b", rb, 32'hCAFE_F00D);
    end
    chk("alias_lat_b", 32'(lb), 32'd2);

    // Masked back-to-back reads on A
    mask_en = 1'b1; valid = 1'b1; address = 32'h10; wstrb = 4'h0; n = 0;
    for (int j = 0; j < 40 && n < 3; j++) begin
      cycle();
      if (rdy_s[0]) begin
        tm[n] = cyc - 1;
        n++;
        if (n < 3) begin valid = 1'b1; address = 32'h10 + 32'(4 * n); end
      end
    end
    valid = 1'b0; mask_en = 1'b0;
    chk("b2b_count", 32'(n), 32'd3);
    if (n == 3) begin
      chk("b2b_gap1", 32'(tm[1] - tm[0]), 32'd5);
      chk("b2b_gap2", 32'(tm[2] - tm[1]), 32'd5);
    end
    extra = 0;
    for (int j = 0; j < 10; j++) begin
      cycle();
      if (rdy_s[0]) extra++;
    end
    chk("b2b_no_extra", 32'(extra), 32'd0);

    // Reset during the wait of a write
    txn(32'h30, 32'h7777_0000, 4'hF, ra, rb, la, lb, rn);
    valid = 1'b1; address = 32'h30; wdata = 32'h5555_5555; wstrb = 4'hF;
    cycle();
    valid = 1'b0;
    resetn = 1'b0;
    extra = 0;
    for (int j = 0; j < 3; j++) begin
      cycle();
      if (rdy_s[0] || rdy_s[1]) extra++;
    end
    resetn = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cycle();
      if (rdy_s[0] || rdy_s[1]) extra++;
    end
    chk("rst_no_ready", 32'(extra), 32'd0);
    txn(32'h30, 32'h0, 4'h0, ra, rb, la, lb, rn);
    chk("rst_old_a", ra, 32'h7777_0000);
    chk("rst_old_b", rb, 32'h7777_0000);

    // Random traffic, including held/dropped valid, aliasing and sporadic resets
    rst_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      valid   = ($urandom_range(0, 2) == 0);
      address = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) address[20] = 1'b1;
      wdata   = $urandom;
      wstrb   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) resetn = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        resetn = 1'b0;
        rst_hold = 2;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
